// File: rtl/serial_parallel_multiplier.sv
// Signed serial-parallel multiplier: one multiplier bit per clock, N-bit multiplicand adder.
// Ports:
//   clk    - system clock (rising edge)
//   rst    - asynchronous active-low reset
//   start  - request, accepted in IDLE or DONE
//   a      - signed multiplicand (N bits), latched on the accepting edge
//   b      - signed multiplier (N bits), latched on the accepting edge
//   result - registered signed product a*b (2N bits), held until the next product completes
//   done   - registered product-valid level
module serial_parallel_multiplier #(
  parameter int unsigned N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic [2*N-1:0]   result,
  output logic             done
);

  localparam int unsigned W  = 2 * N;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_acc;
  logic [N-1:0]    r_mplier;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    w_addend;
  logic [W-1:0]    w_acc_next;
  logic            w_accept;
  logic            w_last;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next state and accumulator step; the sign bit carries negative weight
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = (r_cnt == CW'(N - 1));
    w_addend     = r_mcand << r_cnt;
    w_acc_next   = r_acc;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (r_mplier[0]) begin
          w_acc_next = w_last ? (r_acc - w_addend) : (r_acc + w_addend);
        end
        if (w_last) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{N{a[N-1]}}, a};
      r_mplier <= b;
      r_acc    <= '0;
      r_cnt    <= '0;
      done     <= 1'b0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        result <= w_acc_next;
        done   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_parallel_multiplier.sv
// Directed bench for serial_parallel_multiplier with an N=2 and an N=8 instance.
module tb_serial_parallel_multiplier;

  logic        clk;
  logic        rst;
  logic        start2;
  logic [1:0]  a2;
  logic [1:0]  b2;
  logic [3:0]  result2;
  logic        done2;
  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] result8;
  logic        done8;

  int checks;
  int failures;

  serial_parallel_multiplier #(.N(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .result(result2), .done(done2)
  );

  serial_parallel_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .result(result8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one N=2 operation; lat = edges from accept to done, -1 on timeout
  task automatic run2(input int av, input int bv, output int lat);
    a2 = 2'(av);
    b2 = 2'(bv);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run8(input int av, input int bv, output int lat);
    a8 = 8'(av);
    b8 = 8'(bv);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done2 !== 1'b0 || result2 !== 4'h0) begin
      failures++;
      $display("FAIL reset_n2 got done=%b result=%h exp done=0 result=0", done2, result2);
    end
    checks++;
    if (done8 !== 1'b0 || result8 !== 16'h0) begin
      failures++;
      $display("FAIL reset_n8 got done=%b result=%h exp done=0 result=0", done8, result8);
    end
    rst = 1'b1;
  endtask

  task automatic test_exhaustive_n2();
    int lat;
    for (int av = -2; av <= 1; av++) begin
      for (int bv = -2; bv <= 1; bv++) begin
        run2(av, bv, lat);
        checks++;
        if (lat != 2) begin
          failures++;
          $display("FAIL exh_lat a=%0d b=%0d got=%0d exp=2", av, bv, lat);
        end
        checks++;
        if (result2 !== 4'(av * bv)) begin
          failures++;
          $display("FAIL exh_result a=%0d b=%0d got=%h exp=%h", av, bv, result2, 4'(av * bv));
        end
      end
    end
  endtask

  task automatic test_latency_n2();
    a2 = 2'(-2);
    b2 = 2'(1);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    a2 = 2'(1);
    b2 = 2'(1);
    @(posedge clk); #1;
    checks++;
    if (done2 !== 1'b0) begin
      failures++;
      $display("FAIL lat_e1_done got=%b exp=0", done2);
    end
    @(posedge clk); #1;
    checks++;
    if (done2 !== 1'b1 || result2 !== 4'hE) begin
      failures++;
      $display("FAIL lat_e2 got done=%b result=%h exp done=1 result=e", done2, result2);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done2 !== 1'b1 || result2 !== 4'hE) begin
        failures++;
        $display("FAIL lat_hold c=%0d got done=%b result=%h exp done=1 result=e", c, done2, result2);
      end
    end
  endtask

  task automatic test_corners_n8();
    int ta[4] = '{-128, 127, -1, 127};
    int tb[4] = '{-128, -128, -1, 127};
    logic [15:0] te[4] = '{16'h4000, 16'hC080, 16'h0001, 16'h3F01};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run8(ta[i], tb[i], lat);
      checks++;
      if (lat != 8) begin
        failures++;
        $display("FAIL corner_lat i=%0d got=%0d exp=8", i, lat);
      end
      checks++;
      if (result8 !== te[i]) begin
        failures++;
        $display("FAIL corner_result i=%0d got=%h exp=%h", i, result8, te[i]);
      end
    end
  endtask

  task automatic test_start_busy_n8();
    int lat;
    a8 = 8'd100;
    b8 = 8'(-3);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'd7;
    b8 = 8'd9;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) begin
        a8 = 8'd5;
        b8 = 8'd5;
        start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
    end
    start8 = 1'b0;
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL busy_lat got=%0d exp=8", lat);
    end
    checks++;
    if (result8 !== 16'hFED4) begin
      failures++;
      $display("FAIL busy_result got=%h exp=fed4", result8);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    a8 = 8'd100;
    b8 = 8'(-3);
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (done8 !== 1'b0 || result8 !== 16'h0) begin
      failures++;
      $display("FAIL areset_n8 got done=%b result=%h exp done=0 result=0", done8, result8);
    end
    checks++;
    if (done2 !== 1'b0 || result2 !== 4'h0) begin
      failures++;
      $display("FAIL areset_n2 got done=%b result=%h exp done=0 result=0", done2, result2);
    end
    #1;
    rst = 1'b1;
    run8(3, -2, lat);
    checks++;
    if (lat != 8 || result8 !== 16'hFFFA) begin
      failures++;
      $display("FAIL areset_after got lat=%0d result=%h exp lat=8 result=fffa", lat, result8);
    end
  endtask

  task automatic test_back_to_back();
    a2 = 2'(1);
    b2 = 2'(-1);
    start2 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      checks++;
      if (done2 !== ((c % 3) == 2)) begin
        failures++;
        $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done2, ((c % 3) == 2));
      end
      if ((c % 3) == 2) begin
        checks++;
        if (result2 !== 4'hF) begin
          failures++;
          $display("FAIL b2b_result c=%0d got=%h exp=f", c, result2);
        end
      end
    end
    start2 = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    start2   = 1'b0;
    a2       = '0;
    b2       = '0;
    start8   = 1'b0;
    a8       = '0;
    b8       = '0;
    @(posedge clk); #1;
    test_reset();
    test_exhaustive_n2();
    test_latency_n2();
    test_corners_n8();
    test_start_busy_n8();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
